// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Grid geometry, direction encoding and FSM states for snake_body.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int GRID_W   = 16;
    localparam int GRID_H   = 8;
    localparam int MAX_LEN  = 50;
    localparam int INIT_LEN = 2;

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = 7;

    localparam int INIT_X = GRID_W / 2;
    localparam int INIT_Y = GRID_H / 2;

    typedef enum logic [3:0] {
        DIR_RIGHT = 4'b0001,
        DIR_LEFT  = 4'b0010,
        DIR_DOWN  = 4'b0100,
        DIR_UP    = 4'b1000
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // Segments past INIT_LEN are don't-care; park them on the head cell.
    function automatic logic [XW-1:0] init_seg_x(input int i);
        return (i < INIT_LEN) ? XW'(INIT_X - i) : XW'(INIT_X);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_body_head_stepper.sv
`default_nettype none
// ============================================================================
// Module      : head_stepper
// Description : Moves a cell one step in a direction and flags leaving the grid.
// Revision    : 1.0 - initial release
// ============================================================================
module head_stepper
    import snake_pkg::*;
(
    input  logic [XW-1:0] curX,
    input  logic [YW-1:0] curY,
    input  dir_t          dir,
    output logic [XW-1:0] nxtX,
    output logic [YW-1:0] nxtY,
    output logic          wall
);

    localparam logic [XW:0] c_one_x = (XW+1)'(1);
    localparam logic [YW:0] c_one_y = (YW+1)'(1);
    localparam logic [XW:0] c_lim_x = (XW+1)'(GRID_W);
    localparam logic [YW:0] c_lim_y = (YW+1)'(GRID_H);

    logic [XW:0] w_x;
    logic [YW:0] w_y;

    // One extra bit: stepping below zero gives all-ones, which lands above the limit.
    always_comb begin
        w_x = {1'b0, curX};
        w_y = {1'b0, curY};
        case (dir)
            DIR_RIGHT: w_x = w_x + c_one_x;
            DIR_LEFT:  w_x = w_x - c_one_x;
            DIR_DOWN:  w_y = w_y + c_one_y;
            DIR_UP:    w_y = w_y - c_one_y;
            default: begin end
        endcase
    end

    assign nxtX = w_x[XW-1:0];
    assign nxtY = w_y[YW-1:0];
    assign wall = (w_x >= c_lim_x) || (w_y >= c_lim_y);

endmodule
`default_nettype wire

// File: rtl/snake_body.sv
`default_nettype none
// ============================================================================
// Module      : snake_body
// Description : Snake segment list, move/collision FSM and cell-occupancy query.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_body
    import snake_pkg::*;
(
    input  logic          clk,
    input  logic          nRst,
    input  logic          step,
    input  logic [3:0]    direction,
    input  logic [XW-1:0] appleX,
    input  logic [YW-1:0] appleY,
    input  logic          appleValid,
    input  logic [XW-1:0] qX,
    input  logic [YW-1:0] qY,
    output logic          qHit,
    output logic [XW-1:0] headX,
    output logic [YW-1:0] headY,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          goodColl,
    output logic          badColl
);

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_seg_x [MAX_LEN];
    logic [YW-1:0] r_seg_y [MAX_LEN];
    logic [LW-1:0] r_len, r_idx, r_limit;
    dir_t          r_heading, r_pend;
    logic [XW-1:0] r_nxt_x;
    logic [YW-1:0] r_nxt_y;
    logic          r_grow, r_hit, r_good, r_bad;

    logic [XW-1:0] w_step_x;
    logic [YW-1:0] w_step_y;
    logic          w_wall, w_grow, w_dir_ok, w_match, w_scan_end;
    logic [MAX_LEN-1:0] w_seg_hit;

    head_stepper u_head_stepper (
        .curX (r_seg_x[0]),
        .curY (r_seg_y[0]),
        .dir  (r_pend),
        .nxtX (w_step_x),
        .nxtY (w_step_y),
        .wall (w_wall)
    );

    assign w_grow     = appleValid && (w_step_x == appleX) && (w_step_y == appleY);
    assign w_dir_ok   = $onehot(direction) && (direction != reverse_dir(r_heading));
    assign w_match    = (r_seg_x[r_idx] == r_nxt_x) && (r_seg_y[r_idx] == r_nxt_y);
    assign w_scan_end = (r_idx == r_limit - LW'(1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (step) w_state_nxt = CALC;
            CALC:    w_state_nxt = w_wall ? COMMIT : SCAN;
            SCAN:    if (w_match || w_scan_end) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= init_seg_x(i);
                r_seg_y[i] <= YW'(INIT_Y);
            end
            r_len     <= LW'(INIT_LEN);
            r_idx     <= '0;
            r_limit   <= '0;
            r_heading <= DIR_RIGHT;
            r_pend    <= DIR_RIGHT;
            r_nxt_x   <= '0;
            r_nxt_y   <= '0;
            r_grow    <= 1'b0;
            r_hit     <= 1'b0;
            r_good    <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_good <= 1'b0;
            r_bad  <= 1'b0;
            if (w_dir_ok) r_pend <= dir_t'(direction);
            case (r_state)
                CALC: begin
                    r_nxt_x <= w_step_x;
                    r_nxt_y <= w_step_y;
                    r_grow  <= w_grow;
                    // When not growing the tail moves away, so it cannot be hit.
                    r_limit <= w_grow ? r_len : r_len - LW'(1);
                    r_hit   <= w_wall;
                    r_idx   <= '0;
                end
                SCAN: begin
                    if (w_match) r_hit <= 1'b1;
                    else         r_idx <= r_idx + LW'(1);
                end
                COMMIT: begin
                    if (r_hit) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= init_seg_x(i);
                            r_seg_y[i] <= YW'(INIT_Y);
                        end
                        r_len     <= LW'(INIT_LEN);
                        r_heading <= DIR_RIGHT;
                        r_pend    <= DIR_RIGHT;
                        r_bad     <= 1'b1;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= r_seg_x[i-1];
                            r_seg_y[i] <= r_seg_y[i-1];
                        end
                        r_seg_x[0] <= r_nxt_x;
                        r_seg_y[0] <= r_nxt_y;
                        r_heading  <= r_pend;
                        if (r_grow) begin
                            r_good <= 1'b1;
                            if (r_len < LW'(MAX_LEN)) r_len <= r_len + LW'(1);
                        end
                    end
                end
                default: begin end
            endcase
        end
    end

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_qhit
        assign w_seg_hit[gi] = (LW'(gi) < r_len) && (r_seg_x[gi] == qX) && (r_seg_y[gi] == qY);
    end

    assign qHit     = |w_seg_hit;
    assign headX    = r_seg_x[0];
    assign headY    = r_seg_y[0];
    assign length   = r_len;
    assign busy     = (r_state != IDLE);
    assign goodColl = r_good;
    assign badColl  = r_bad;

endmodule
`default_nettype wire

// File: doc/snake_body.md
Name: snake_body

Overview:
- Upstream neighbour of score_tracker. Holds the snake's segment list and advances it one cell per step pulse.
- Detects apple hits, wall hits and self hits, and emits one-cycle goodColl/badColl pulses that wire directly to score_tracker.
- Also answers a combinational cell-occupancy query for the LED display stage.

Parameters:
GRID_W, 16, grid columns; XW = $clog2(GRID_W)
GRID_H, 8, grid rows; YW = $clog2(GRID_H)
MAX_LEN, 50, maximum segments; matches score_tracker maxScore; LW = 7
INIT_LEN, 2, length after reset or after badColl

Ports:
clk  in  1  system clock (hz100 domain)
nRst  in  1  asynchronous active-low reset
step  in  1  one-cycle move tick
direction  in  4  one-cycle one-hot pulse from posedge_detector: [3]=up, [2]=down, [1]=left, [0]=right
appleX  in  XW  apple column
appleY  in  YW  apple row
appleValid  in  1  apple present
qX  in  XW  display query column
qY  in  YW  display query row
qHit  out  1  combinational: some segment with index < length equals (qX,qY)
headX  out  XW  segment 0 column
headY  out  YW  segment 0 row; y=0 is the top row, up decrements y
length  out  LW  current segment count
busy  out  1  FSM not in IDLE
goodColl  out  1  one-cycle pulse: apple eaten
badColl  out  1  one-cycle pulse: wall or self hit

Behaviour:
- Reset (async, nRst=0):
  - seg[0]=(GRID_W/2, GRID_H/2)=(8,4); seg[i]=(8-i,4) for i<INIT_LEN; length=INIT_LEN.
  - heading=pendDir=right.
  - goodColl=badColl=busy=0; state=IDLE.
  - Reset mid-operation abandons the move; no pulse is emitted.
- Direction handling, evaluated every cycle in any state:
  - An exactly-one-hot direction that is not the reverse of heading loads pendDir.
  - A reversal, zero, or multi-hot value is ignored.
  - heading updates only in COMMIT.
- FSM states IDLE, CALC, SCAN, COMMIT:
  - IDLE: step=1 -> CALC. A step arriving in any other state is dropped; no queueing.
  - CALC (1 cycle):
    - nextHead = seg[0] moved one cell by pendDir.
    - wall = result out of range (x<0, x>=GRID_W, y<0, y>=GRID_H).
    - grow = appleValid && nextHead==(appleX,appleY).
    - scanLimit = grow ? length : length-1. The tail cell is vacated unless growing.
    - wall -> COMMIT with hit=1; else idx=0 -> SCAN.
  - SCAN (1 compare per cycle):
    - seg[idx]==nextHead -> hit=1, go to COMMIT (early exit).
    - else idx++; idx==scanLimit-1 with no match -> COMMIT.
  - COMMIT (1 cycle):
    - hit=1: reload the reset body, length=INIT_LEN, heading=pendDir=right; badColl<=1.
    - hit=0: seg[i]<=seg[i-1] for i>=1; seg[0]<=nextHead; heading<=pendDir.
    - hit=0 and grow: length<=min(length+1, MAX_LEN); goodColl<=1. goodColl still pulses at MAX_LEN, but there is no growth.
    - Next state IDLE.
- Outputs:
  - goodColl and badColl are registered and high only in the cycle after COMMIT; they are never both high.
  - headX/headY/length reflect the committed move in that same cycle.
- Latency: step at cycle t -> pulses at t+3+S, where S = number of SCAN cycles (1..MAX_LEN; 0 on a wall hit). Step spacing must be >= MAX_LEN+4 cycles.
- Width rules:
  - Next-head arithmetic is done at XW+1 / YW+1 signed width so underflow is detected; no wrap-around.
  - Segments with index >= length hold stale values and are ignored by qHit and SCAN.

Decomposition:
- snake_pkg:
  - dir_t one-hot encoding with UP/DOWN/LEFT/RIGHT constants.
  - state_t enum {IDLE, CALC, SCAN, COMMIT}.
  - Widths XW, YW, LW.
  - INIT_X=8, INIT_Y=4.
- Sub-module head_stepper (combinational): inputs curX, curY, dir; outputs nxtX, nxtY, wall.

Test Plan:
- Reset release, no input -> head (8,4), length 2, busy=0, qHit=1 at (7,4), qHit=0 at (6,4).
- Step at cycle 0, no apple -> busy cycles 1-3 (S=1); cycle 4: head (9,4), goodColl=badColl=0.
- Left pulse while heading right, then step -> reversal ignored; head (9,4).
- Apples at (9,4), (10,4), (11,4) on three successive steps -> three goodColl pulses; length 5; body (11,4),(10,4),(9,4),(8,4),(7,4).
- From that state: up, step; left, step; down, step -> the third move hits seg[3]=(10,4); badColl for one cycle; body reloads to head (8,4), length 2.
- Eight steps right from reset -> seventh step reaches x=15; eighth step raises badColl with S=0 (pulse at t+3). Also: step asserted while busy is dropped, and nRst pulsed during SCAN gives no pulse plus the reset body.
